// File: rtl/seg7_scan_driver_if.sv
// Connection bundle between the lock logic and the 4-digit seven-segment scan driver.
// The master side supplies the display data; the slave side (the driver) returns status and the pin drive.
interface seg7_scan_driver_if;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic [3:0]  blank_mask;
  logic        load;
  logic        pending;
  logic        frame_done;
  logic [3:0]  segEn;
  logic [6:0]  sevSeg;
  logic        segDec;

  modport master (
    output value, dp_mask, blank_mask, load,
    input  pending, frame_done, segEn, sevSeg, segDec
  );

  modport slave (
    input  value, dp_mask, blank_mask, load,
    output pending, frame_done, segEn, sevSeg, segDec
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 4-digit display driver with frame-boundary double buffering.
// All pin outputs are registered one cycle after the scan position and active data they reflect.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_driver_if.slave  bus
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW:0]   GUARD_C  = (CW + 1)'(GUARD);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dig_q, dig_d;
  logic [15:0]   act_value_q, act_value_d;
  logic [3:0]    act_dp_q, act_dp_d;
  logic [3:0]    act_blank_q, act_blank_d;
  logic [15:0]   pend_value_q, pend_value_d;
  logic [3:0]    pend_dp_q, pend_dp_d;
  logic [3:0]    pend_blank_q, pend_blank_d;
  logic          pend_flag_q, pend_flag_d;
  logic          frame_done_q, frame_done_d;
  logic [3:0]    seg_en_q, seg_en_d;
  logic [6:0]    sev_seg_q, sev_seg_d;
  logic          seg_dec_q, seg_dec_d;
  logic          cnt_wrap_s;
  logic          boundary_s;

  // Scan position, double-buffer commit and next pin values.
  always_comb begin
    cnt_wrap_s   = (cnt_q == CNT_LAST);
    boundary_s   = cnt_wrap_s && (dig_q == 2'd3);
    cnt_d        = cnt_wrap_s ? '0 : cnt_q + CW'(1);
    dig_d        = cnt_wrap_s ? dig_q + 2'd1 : dig_q;
    act_value_d  = act_value_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    pend_value_d = pend_value_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_flag_d  = pend_flag_q;

    // A load on the boundary bypasses the staging registers entirely.
    if (boundary_s) begin
      if (bus.load) begin
        act_value_d = bus.value;
        act_dp_d    = bus.dp_mask;
        act_blank_d = bus.blank_mask;
      end else if (pend_flag_q) begin
        act_value_d = pend_value_q;
        act_dp_d    = pend_dp_q;
        act_blank_d = pend_blank_q;
      end else begin
        act_value_d = act_value_q;
      end
      pend_flag_d = 1'b0;
    end else if (bus.load) begin
      pend_value_d = bus.value;
      pend_dp_d    = bus.dp_mask;
      pend_blank_d = bus.blank_mask;
      pend_flag_d  = 1'b1;
    end else begin
      pend_flag_d = pend_flag_q;
    end

    frame_done_d = (cnt_d == CNT_LAST) && (dig_d == 2'd3);

    seg_en_d  = 4'hF;
    sev_seg_d = 7'h7F;
    seg_dec_d = 1'b1;
    if ({1'b0, cnt_q} < GUARD_C) begin
      seg_en_d = 4'hF;
    end else if (act_blank_q[dig_q]) begin
      seg_en_d = 4'hF;
    end else begin
      seg_en_d  = ~(4'b0001 << dig_q);
      sev_seg_d = hex_to_seg(act_value_q[{dig_q, 2'b00} +: 4]);
      seg_dec_d = ~act_dp_q[dig_q];
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      dig_q        <= 2'd0;
      act_value_q  <= 16'h0000;
      act_dp_q     <= 4'h0;
      act_blank_q  <= 4'hF;
      pend_value_q <= 16'h0000;
      pend_dp_q    <= 4'h0;
      pend_blank_q <= 4'hF;
      pend_flag_q  <= 1'b0;
      frame_done_q <= 1'b0;
      seg_en_q     <= 4'hF;
      sev_seg_q    <= 7'h7F;
      seg_dec_q    <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      dig_q        <= dig_d;
      act_value_q  <= act_value_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      pend_value_q <= pend_value_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_flag_q  <= pend_flag_d;
      frame_done_q <= frame_done_d;
      seg_en_q     <= seg_en_d;
      sev_seg_q    <= sev_seg_d;
      seg_dec_q    <= seg_dec_d;
    end
  end

  assign bus.pending    = pend_flag_q;
  assign bus.frame_done = frame_done_q;
  assign bus.segEn      = seg_en_q;
  assign bus.sevSeg     = sev_seg_q;
  assign bus.segDec     = seg_dec_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a time-indexed display model checked every cycle, plus directed literal checks.
module tb_seg7_scan_driver;
  localparam int R = 4;
  localparam int G = 1;
  localparam int FRAME = 4 * R;

  localparam logic [6:0] HEX_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  seg7_scan_driver_if bif ();

  seg7_scan_driver #(.REFRESH_DIV(R), .GUARD(G)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position in the frame is just the number of cycles since reset.
  bit          m_valid = 1'b0;
  int          m_t;
  logic [15:0] m_av, m_pv;
  logic [3:0]  m_adp, m_abl, m_pdp, m_pbl;
  logic        m_pend;
  logic [3:0]  e_en;
  logic [6:0]  e_seg;
  logic        e_dp;

  function automatic int dig_of(input int t);
    return (t / R) % 4;
  endfunction

  function automatic logic [3:0] nib(input logic [15:0] v, input int d);
    return v[4*d +: 4];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b1;
      m_t     <= 0;
      m_av    <= 16'h0000;
      m_adp   <= 4'h0;
      m_abl   <= 4'hF;
      m_pend  <= 1'b0;
      e_en    <= 4'hF;
      e_seg   <= 7'h7F;
      e_dp    <= 1'b1;
    end else if (m_valid) begin
      m_t <= m_t + 1;
      if ((m_t % R) < G || m_abl[dig_of(m_t)]) begin
        e_en  <= 4'hF;
        e_seg <= 7'h7F;
        e_dp  <= 1'b1;
      end else begin
        e_en  <= ~(4'b0001 << dig_of(m_t));
        e_seg <= HEX_TAB[nib(m_av, dig_of(m_t))];
        e_dp  <= ~m_adp[dig_of(m_t)];
      end
      if ((m_t % FRAME) == FRAME - 1) begin
        if (bif.load) begin
          m_av <= bif.value; m_adp <= bif.dp_mask; m_abl <= bif.blank_mask;
        end else if (m_pend) begin
          m_av <= m_pv; m_adp <= m_pdp; m_abl <= m_pbl;
        end
        m_pend <= 1'b0;
      end else if (bif.load) begin
        m_pv <= bif.value; m_pdp <= bif.dp_mask; m_pbl <= bif.blank_mask;
        m_pend <= 1'b1;
      end
    end
  end

  bit in_t3 = 1'b0;
  bit seen_a = 1'b0;

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("segEn", {12'h0, bif.segEn}, {12'h0, e_en});
      chk("sevSeg", {9'h0, bif.sevSeg}, {9'h0, e_seg});
      chk("segDec", {15'h0, bif.segDec}, {15'h0, e_dp});
      chk("frame_done", {15'h0, bif.frame_done}, {15'h0, ((m_t % FRAME) == FRAME - 1)});
      chk("pending", {15'h0, bif.pending}, {15'h0, m_pend});
      chk("one_anode", 16'($countones(~bif.segEn) <= 1), 16'h1);
      if (in_t3 && bif.segEn != 4'hF && bif.sevSeg == 7'b0001000) seen_a = 1'b1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fd();
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!bif.frame_done && i < 40);
    if (!bif.frame_done) chk("fd_timeout", 16'h0, 16'h1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    bif.value = v; bif.dp_mask = dp; bif.blank_mask = bl; bif.load = 1'b1;
    step(1);
    bif.load = 1'b0;
  endtask

  initial begin
    int fd_cnt;
    int k;
    bif.value = 16'h0; bif.dp_mask = 4'h0; bif.blank_mask = 4'h0; bif.load = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_segEn", {12'h0, bif.segEn}, 16'h000F);
    chk("reset_sevSeg", {9'h0, bif.sevSeg}, 16'h007F);

    // 1: idle, display dark, frame_done every 16 cycles
    fd_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bif.frame_done) fd_cnt++;
    end
    chk("idle_fd_count", 16'(fd_cnt), 16'd4);
    chk("idle_pending", {15'h0, bif.pending}, 16'h0);

    // 2: mid-frame load waits for the boundary
    wait_fd();
    step(5);
    do_load(16'h1234, 4'h0, 4'h0);
    chk("t2_pending_set", {15'h0, bif.pending}, 16'h1);
    wait_fd();
    chk("t2_pending_at_bnd", {15'h0, bif.pending}, 16'h1);
    step(3);
    chk("t2_dig0_seg", {9'h0, bif.sevSeg}, 16'b0011001);
    chk("t2_dig0_en", {12'h0, bif.segEn}, 16'b1110);
    chk("t2_pending_clr", {15'h0, bif.pending}, 16'h0);
    step(12);
    chk("t2_dig3_seg", {9'h0, bif.sevSeg}, 16'b1111001);
    chk("t2_dig3_en", {12'h0, bif.segEn}, 16'b0111);

    // 3: two loads in one frame, last wins
    in_t3 = 1'b1;
    wait_fd();
    step(2);
    do_load(16'hAAAA, 4'h0, 4'h0);
    do_load(16'h5555, 4'h0, 4'h0);
    wait_fd();
    step(3);
    chk("t3_dig0_seg", {9'h0, bif.sevSeg}, 16'b0010010);
    wait_fd();
    in_t3 = 1'b0;
    chk("t3_never_A", {15'h0, seen_a}, 16'h0);

    // 4: load exactly on the boundary cycle
    wait_fd();
    do_load(16'h9ABC, 4'h0, 4'h0);
    chk("t4_no_pending", {15'h0, bif.pending}, 16'h0);
    step(2);
    chk("t4_dig0_seg", {9'h0, bif.sevSeg}, 16'b1000110);
    chk("t4_dig0_en", {12'h0, bif.segEn}, 16'b1110);

    // 5: decimal point and blanking masks
    wait_fd();
    step(2);
    do_load(16'h1234, 4'b0100, 4'b1000);
    wait_fd();
    step(11);
    chk("t5_dig2_dp", {15'h0, bif.segDec}, 16'h0);
    chk("t5_dig2_en", {12'h0, bif.segEn}, 16'b1011);
    step(4);
    chk("t5_dig3_dark", {12'h0, bif.segEn}, 16'h000F);
    chk("t5_dig3_dp", {15'h0, bif.segDec}, 16'h1);

    // 6: reset mid-slot with pending data, and a load coinciding with reset
    wait_fd();
    step(2);
    do_load(16'hFEDC, 4'h0, 4'h0);
    step(8);
    chk("t6_pending_before", {15'h0, bif.pending}, 16'h1);
    rst = 1'b1;
    bif.value = 16'h8888; bif.load = 1'b1;
    step(1);
    rst = 1'b0;
    bif.load = 1'b0;
    chk("t6_dark_en", {12'h0, bif.segEn}, 16'h000F);
    chk("t6_dark_seg", {9'h0, bif.sevSeg}, 16'h007F);
    chk("t6_pending_clr", {15'h0, bif.pending}, 16'h0);
    k = 0;
    while (!bif.frame_done && k < 40) begin
      step(1);
      k++;
    end
    chk("t6_restart_fd", 16'(k), 16'd15);
    step(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
